intr_ack_sequencer: RTL and testbench
=====================================

// Module: intr_ack_sequencer
// PURPOSE
//  Parametrised interrupt control core: masks NUM_IRQ request lines and resolves priority (fixed or rotating, fully nested).
//  Runs the two-pulse INTA vector handshake, poll reads, and specific/non-specific EOI.
//  Sits between the edge/level request latch and the CPU data-bus buffer, and generalises the 8-line control logic.
// PARAMETERS
//  NUM_IRQ       8  request channels; power of 2, 2..64; ID_W = $clog2(NUM_IRQ)
//  VECTOR_WIDTH  8  vector width; VECTOR_WIDTH > ID_W; CFG_W = max(NUM_IRQ, VECTOR_WIDTH)
// PORTS
//  clock                    in   1        single clock
//  reset                    in   1        asynchronous, active-high
//  irq_request              in   NUM_IRQ  latched requests (IRR)
//  irq_clear                out  NUM_IRQ  1-cycle pulse: clear IRR bit on latch
//  interrupt_acknowledge_n  in   1        INTA#, sampled by clock
//  int_to_cpu               out  1        interrupt request to CPU
//  vector_valid             out  1        drive vector_out onto bus
//  vector_out               out  VW       {base[VW-1:ID_W], id}
//  cfg_write                in   1        1-cycle write strobe
//  cfg_addr                 in   2        0 MASK, 1 BASE, 2 EOI, 3 MODE
//  cfg_wdata                in   CFG_W    write data
//  read                     in   1        CPU read strobe, poll state only
//  read_data                out  8        poll word
//  in_service               out  NUM_IRQ  ISR
// BEHAVIOUR
//  Reset values: all outputs 0; imr=0, base=0, ISR=0, rot=NUM_IRQ-1, state IDLE.
//  pending = irq_request & ~imr. Priority order starts at rot+1 (mod NUM_IRQ) and descends.
//  int_to_cpu is registered. It rises 1 cycle after the top pending request outranks the top ISR bit.
//   It falls at the end of an ACK sequence or a poll.
//  ACK edges come from a registered copy of interrupt_acknowledge_n. The edge acts in the cycle it is seen.
//  FSM states: IDLE, ACK1, ACK2, POLL.
//   IDLE -fall-> ACK1: latch winner id, set ISR[id], pulse irq_clear[id].
//     If nothing is pending, the sequence is spurious: id=NUM_IRQ-1, ISR and irq_clear untouched.
//   ACK1 -rise-> ACK2. In ACK1, vector_valid=0.
//   ACK2, while INTA# low: vector_valid=1 and vector_out holds the latched id. ACK2 -rise-> IDLE (end of sequence).
//   IDLE + MODE write with wdata[2]=1 -> POLL.
//    POLL, read high: read_data = {1'b1, winner id zero-extended} if pending, else 8'h00.
//    Rising edge of read: latch as in ACK1. Falling edge of read -> IDLE (end of poll).
//  EOI wdata[7:6]:
//   01 = clear highest ISR bit.
//   11 = clear ISR[wdata[ID_W-1:0]].
//   10 = clear highest ISR bit and set rot to it.
//   00 = no-op.
//  MODE: wdata[0] = auto_rotate (rot <= id at end of sequence); wdata[1] = aeoi (macro only).
//  Simultaneous events:
//   Config write and ACK edge in one cycle: both take effect.
//   New imr/rot values affect resolution from the next cycle.
//   ISR set and ISR clear on the same bit: set wins.
//   Requests arriving during ACK1/ACK2 do not change the latched id.
//  Reset mid-sequence: immediately IDLE, vector_valid=0, ISR cleared.
// CONFIGURATION
//  AUTO_EOI_EN defined:
//   MODE wdata[1] enables auto-EOI; ISR[id] clears at end of sequence.
//   With auto-EOI on, int_to_cpu ignores ISR nesting.
//  AUTO_EOI_EN undefined: MODE wdata[1] is ignored; ISR clears only by EOI command.
// STRUCTURE
//  intr_ctrl_pkg: cfg address constants, FSM state enum, EOI codes, num2bit/bit2num functions.
//  Sub-module intr_priority_resolver (combinational): rotated find-first over (vector, rot) -> {valid, id}.
//   Instantiated twice: once for pending, once for ISR.
// TESTING
//  1. NUM_IRQ=8, base=0x20, irq_request=0x28, INTA# pulses x2
//     -> vector 0x23 in ACK2, ISR=0x08, irq_clear=0x08 for 1 cycle.
//  2. ISR=0x08, then irq_request=0x02 -> int_to_cpu=1; irq_request=0x20 only -> int_to_cpu stays 0.
//  3. MODE=0x01, service IR3 -> rot=3; next, irq_request=0x0C -> IR2 wins, vector 0x22.
//  4. MODE=0x04, irq_request=0x40, read pulse -> read_data=0x86, ISR=0x40, state IDLE after read falls.
//  5. INTA# with pending=0 -> vector {base,7}, ISR unchanged. Assert reset in ACK2 -> vector_valid=0 next edge.
//  6. NUM_IRQ=16, VECTOR_WIDTH=8, base=0x40, IR13 -> vector 0x4D. AUTO_EOI_EN + MODE=0x02 -> ISR=0 after ACK2.

Source files
------------

// File: rtl/intr_ack_sequencer_pkg.sv
// Shared constants, FSM encoding, EOI codes and bit/index helpers for the interrupt ack sequencer.
package intr_ctrl_pkg;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_BASE = 2'd1;
    localparam logic [1:0] CFG_EOI  = 2'd2;
    localparam logic [1:0] CFG_MODE = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_ACK2 = 2'd2;
    localparam logic [1:0] ST_POLL = 2'd3;

    typedef enum logic [1:0] {
        EOI_NOP      = 2'b00,
        EOI_NONSPEC  = 2'b01,
        EOI_ROTATE   = 2'b10,
        EOI_SPECIFIC = 2'b11
    } eoi_code_e;

    function automatic logic [63:0] num2bit(input logic [5:0] n);
        return 64'(1) << n;
    endfunction

    // Index of the set bit of a one-hot word (highest set bit if several).
    function automatic logic [5:0] bit2num(input logic [63:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n = 6'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/intr_ack_sequencer_if.sv
// CPU-side bus of the interrupt ack sequencer: INTA# handshake, vector, config writes and poll reads.
interface intr_ack_sequencer_if #(
    parameter int NUM_IRQ      = 8,
    parameter int VECTOR_WIDTH = 8
);
    localparam int CFG_W = (NUM_IRQ > VECTOR_WIDTH) ? NUM_IRQ : VECTOR_WIDTH;

    logic                    interrupt_acknowledge_n;
    logic                    int_to_cpu;
    logic                    vector_valid;
    logic [VECTOR_WIDTH-1:0] vector_out;
    logic                    cfg_write;
    logic [1:0]              cfg_addr;
    logic [CFG_W-1:0]        cfg_wdata;
    logic                    read;
    logic [7:0]              read_data;

    modport master (
        output interrupt_acknowledge_n, cfg_write, cfg_addr, cfg_wdata, read,
        input  int_to_cpu, vector_valid, vector_out, read_data
    );

    modport slave (
        input  interrupt_acknowledge_n, cfg_write, cfg_addr, cfg_wdata, read,
        output int_to_cpu, vector_valid, vector_out, read_data
    );
endinterface

// File: rtl/intr_ack_sequencer_resolver.sv
// Combinational rotated find-first: the channel after rot has top priority, then ascending ids wrap around.
module intr_priority_resolver #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]         vec,
    input  logic [$clog2(NUM_IRQ)-1:0] rot,
    output logic                       valid,
    output logic [$clog2(NUM_IRQ)-1:0] id
);
    import intr_ctrl_pkg::*;

    localparam int ID_W = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] rotated;
    logic [NUM_IRQ-1:0] grant;

    always_comb begin
        rotated = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            rotated[k] = vec[ID_W'(int'(rot) + 1 + k)];
        end
    end

    // Lowest set bit of the rotated word is the winner's offset from rot+1.
    assign grant = rotated & (~rotated + NUM_IRQ'(1));
    assign valid = |vec;
    assign id    = rot + ID_W'(1) + ID_W'(bit2num(64'(grant)));

endmodule

// File: rtl/intr_ack_sequencer.sv
// Interrupt control core: masking, nested priority, INTA# vector handshake, poll and EOI handling.
// Optional auto-EOI support is compiled in when AUTO_EOI_EN is defined.
module intr_ack_sequencer #(
    parameter int NUM_IRQ      = 8,
    parameter int VECTOR_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_request,
    output logic [NUM_IRQ-1:0] irq_clear,
    output logic [NUM_IRQ-1:0] in_service,
    intr_ack_sequencer_if.slave bus
);
    import intr_ctrl_pkg::*;

    localparam int ID_W  = $clog2(NUM_IRQ);
    localparam int CFG_W = (NUM_IRQ > VECTOR_WIDTH) ? NUM_IRQ : VECTOR_WIDTH;
    localparam int WD_W  = (CFG_W < 8) ? 8 : CFG_W;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IRQ - 1);

    logic [1:0]                     state, state_next;
    logic                           inta_q, read_q;
    logic [NUM_IRQ-1:0]             imr, isr, pending, set_mask, clr_mask, clear_q;
    logic [VECTOR_WIDTH-1:ID_W]     base_hi;
    logic [ID_W-1:0]                rot, id_q, pend_id, isr_id, latch_id;
    logic                           pend_valid, isr_valid, hit_q, auto_rot, int_q, want;
    logic [7:0]                     rd_q;
    logic [WD_W-1:0]                wd;
    eoi_code_e                      eoi_code;
    logic                           ack_fall, ack_rise, rd_rise, rd_fall;
    logic                           latch, ack_end, poll_end;
    logic                           wr_mask, wr_base, wr_eoi, wr_mode;
`ifdef AUTO_EOI_EN
    logic                           aeoi;
`endif

    // Rank 0 is the highest priority under the current rotation.
    function automatic logic [ID_W-1:0] rank_of(input logic [ID_W-1:0] x, input logic [ID_W-1:0] r);
        return x - r - ID_W'(1);
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] n);
        return NUM_IRQ'(num2bit(6'(n)));
    endfunction

    assign pending  = irq_request & ~imr;
    assign wd       = WD_W'(bus.cfg_wdata);
    assign eoi_code = eoi_code_e'(wd[7:6]);
    assign wr_mask  = bus.cfg_write && (bus.cfg_addr == CFG_MASK);
    assign wr_base  = bus.cfg_write && (bus.cfg_addr == CFG_BASE);
    assign wr_eoi   = bus.cfg_write && (bus.cfg_addr == CFG_EOI);
    assign wr_mode  = bus.cfg_write && (bus.cfg_addr == CFG_MODE);

    assign ack_fall = inta_q && !bus.interrupt_acknowledge_n;
    assign ack_rise = !inta_q && bus.interrupt_acknowledge_n;
    assign rd_rise  = bus.read && !read_q;
    assign rd_fall  = !bus.read && read_q;
    assign latch    = ((state == ST_IDLE) && ack_fall) || ((state == ST_POLL) && rd_rise);
    assign ack_end  = (state == ST_ACK2) && ack_rise;
    assign poll_end = (state == ST_POLL) && rd_fall;

    intr_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_pend_res (
        .vec(pending), .rot(rot), .valid(pend_valid), .id(pend_id)
    );
    intr_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
        .vec(isr), .rot(rot), .valid(isr_valid), .id(isr_id)
    );

    // With nothing pending the sequence is spurious and reports the lowest-numbered-last id.
    assign latch_id = pend_valid ? pend_id : LAST_ID;
    assign set_mask = (latch && pend_valid) ? onehot(pend_id) : '0;

    always_comb begin
        want = pend_valid && (!isr_valid || (rank_of(pend_id, rot) < rank_of(isr_id, rot)));
`ifdef AUTO_EOI_EN
        if (aeoi) want = pend_valid;
`endif
    end

    always_comb begin
        clr_mask = '0;
        if (wr_eoi) begin
            case (eoi_code)
                EOI_NONSPEC, EOI_ROTATE: if (isr_valid) clr_mask = onehot(isr_id);
                EOI_SPECIFIC:            clr_mask = onehot(wd[ID_W-1:0]);
                default:                 ;
            endcase
        end
`ifdef AUTO_EOI_EN
        if (ack_end && aeoi && hit_q) clr_mask = clr_mask | onehot(id_q);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ack_fall)                state_next = ST_ACK1;
                else if (wr_mode && wd[2])   state_next = ST_POLL;
            end
            ST_ACK1: if (ack_rise) state_next = ST_ACK2;
            ST_ACK2: if (ack_rise) state_next = ST_IDLE;
            ST_POLL: if (rd_fall)  state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            inta_q   <= 1'b1;
            read_q   <= 1'b0;
            imr      <= '0;
            isr      <= '0;
            base_hi  <= '0;
            rot      <= LAST_ID;
            id_q     <= '0;
            hit_q    <= 1'b0;
            auto_rot <= 1'b0;
            int_q    <= 1'b0;
            clear_q  <= '0;
            rd_q     <= '0;
`ifdef AUTO_EOI_EN
            aeoi     <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            inta_q  <= bus.interrupt_acknowledge_n;
            read_q  <= bus.read;
            clear_q <= set_mask;
            isr     <= (isr & ~clr_mask) | set_mask;
            if (latch) begin
                id_q  <= latch_id;
                hit_q <= pend_valid;
            end
            if (wr_mask) imr     <= wd[NUM_IRQ-1:0];
            if (wr_base) base_hi <= wd[VECTOR_WIDTH-1:ID_W];
            if (wr_mode) begin
                auto_rot <= wd[0];
`ifdef AUTO_EOI_EN
                aeoi     <= wd[1];
`endif
            end
            if (wr_eoi && (eoi_code == EOI_ROTATE) && isr_valid) rot <= isr_id;
            else if (ack_end && auto_rot && hit_q)                rot <= id_q;
            if (ack_end || poll_end)   int_q <= 1'b0;
            else if (state == ST_IDLE) int_q <= want;
            if ((state == ST_POLL) && rd_rise) rd_q <= pend_valid ? {1'b1, 7'(pend_id)} : 8'h00;
            else if (rd_fall)                  rd_q <= 8'h00;
        end
    end

    assign irq_clear        = clear_q;
    assign in_service       = isr;
    assign bus.int_to_cpu   = int_q;
    assign bus.vector_valid = (state == ST_ACK2) && !inta_q;
    assign bus.vector_out   = {base_hi, id_q};
    assign bus.read_data    = rd_q;

endmodule

// File: tb/tb_intr_ack_sequencer.sv
// Directed bench for intr_ack_sequencer: 8-channel instance for the core flows, 16-channel for wide vectors.
module tb_intr_ack_sequencer;
    logic        clock = 1'b0;
    logic        rst_a, rst_b;
    logic [7:0]  irq_a, clr_a, isr_a;
    logic [15:0] irq_b, clr_b, isr_b;
    logic [7:0]  vec;
    logic        vv;
    int          checks = 0;
    int          errors = 0;

    intr_ack_sequencer_if #(.NUM_IRQ(8),  .VECTOR_WIDTH(8)) bus_a ();
    intr_ack_sequencer_if #(.NUM_IRQ(16), .VECTOR_WIDTH(8)) bus_b ();

    intr_ack_sequencer #(.NUM_IRQ(8), .VECTOR_WIDTH(8)) dut_a (
        .clock(clock), .reset(rst_a), .irq_request(irq_a),
        .irq_clear(clr_a), .in_service(isr_a), .bus(bus_a)
    );
    intr_ack_sequencer #(.NUM_IRQ(16), .VECTOR_WIDTH(8)) dut_b (
        .clock(clock), .reset(rst_b), .irq_request(irq_b),
        .irq_clear(clr_b), .in_service(isr_b), .bus(bus_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_a(input logic [1:0] a, input logic [7:0] d);
        bus_a.cfg_write = 1'b1;
        bus_a.cfg_addr  = a;
        bus_a.cfg_wdata = d;
        tick();
        bus_a.cfg_write = 1'b0;
    endtask

    task automatic cfg_b(input logic [1:0] a, input logic [15:0] d);
        bus_b.cfg_write = 1'b1;
        bus_b.cfg_addr  = a;
        bus_b.cfg_wdata = d;
        tick();
        bus_b.cfg_write = 1'b0;
    endtask

    // Full two-pulse INTA# cycle on the 8-channel instance; captures the bus during the second pulse.
    task automatic ack_a(output logic [7:0] v, output logic valid);
        bus_a.interrupt_acknowledge_n = 1'b0; tick();
        bus_a.interrupt_acknowledge_n = 1'b1; tick();
        bus_a.interrupt_acknowledge_n = 1'b0; tick();
        valid = bus_a.vector_valid;
        v     = bus_a.vector_out;
        bus_a.interrupt_acknowledge_n = 1'b1; tick();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        irq_a = '0;   irq_b = '0;
        bus_a.interrupt_acknowledge_n = 1'b1; bus_a.cfg_write = 1'b0;
        bus_a.cfg_addr = '0; bus_a.cfg_wdata = '0; bus_a.read = 1'b0;
        bus_b.interrupt_acknowledge_n = 1'b1; bus_b.cfg_write = 1'b0;
        bus_b.cfg_addr = '0; bus_b.cfg_wdata = '0; bus_b.read = 1'b0;
        tick(); tick();
        chk("rst_int",  bus_a.int_to_cpu,   0);
        chk("rst_vv",   bus_a.vector_valid, 0);
        chk("rst_vec",  bus_a.vector_out,   0);
        chk("rst_isr",  isr_a,              0);
        chk("rst_clr",  clr_a,              0);
        chk("rst_rd",   bus_a.read_data,    0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Basic vector handshake: IR3 beats IR5 with default priority.
        cfg_a(2'd1, 8'h20);
        irq_a = 8'h28; tick();
        chk("t1_int", bus_a.int_to_cpu, 1);
        bus_a.interrupt_acknowledge_n = 1'b0; tick();
        chk("t1_clr_pulse", clr_a, 8'h08);
        chk("t1_isr", isr_a, 8'h08);
        chk("t1_vv_ack1", bus_a.vector_valid, 0);
        irq_a = 8'h20; tick();
        chk("t1_clr_end", clr_a, 8'h00);
        bus_a.interrupt_acknowledge_n = 1'b1; tick();
        bus_a.interrupt_acknowledge_n = 1'b0; tick();
        chk("t1_vv_ack2", bus_a.vector_valid, 1);
        chk("t1_vec", bus_a.vector_out, 8'h23);
        bus_a.interrupt_acknowledge_n = 1'b1; tick();
        chk("t1_vv_end", bus_a.vector_valid, 0);
        chk("t1_int_end", bus_a.int_to_cpu, 0);

        // Nesting: lower priority stays blocked, higher priority interrupts.
        tick();
        chk("t2_low_blocked", bus_a.int_to_cpu, 0);
        irq_a = 8'h02; tick();
        chk("t2_high_nests", bus_a.int_to_cpu, 1);
        irq_a = 8'h00;
        cfg_a(2'd2, 8'h40);
        chk("t2_eoi_nonspec", isr_a, 8'h00);

        // Auto-rotate and specific EOI.
        cfg_a(2'd3, 8'h01);
        irq_a = 8'h08; tick();
        ack_a(vec, vv);
        chk("t3_first_vec", vec, 8'h23);
        irq_a = 8'h0C; tick();
        chk("t3_int", bus_a.int_to_cpu, 1);
        ack_a(vec, vv);
        chk("t3_vv", vv, 1);
        chk("t3_vec_ir2", vec, 8'h22);
        chk("t3_isr", isr_a, 8'h0C);
        irq_a = 8'h00;
        cfg_a(2'd2, 8'hC3);
        chk("t3_eoi_spec3", isr_a, 8'h04);
        cfg_a(2'd2, 8'hC2);
        chk("t3_eoi_spec2", isr_a, 8'h00);
        irq_a = 8'h09; tick();
        ack_a(vec, vv);
        chk("t3_rot_ir3_wins", vec, 8'h23);
        irq_a = 8'h00;
        cfg_a(2'd3, 8'h00);
        cfg_a(2'd2, 8'h80);
        chk("t3_eoi_rot", isr_a, 8'h00);

        // Poll read.
        cfg_a(2'd3, 8'h04);
        irq_a = 8'h40;
        bus_a.read = 1'b1; tick();
        chk("t4_rd", bus_a.read_data, 8'h86);
        chk("t4_clr", clr_a, 8'h40);
        chk("t4_isr", isr_a, 8'h40);
        bus_a.read = 1'b0; tick();
        chk("t4_rd_end", bus_a.read_data, 8'h00);
        irq_a = 8'h00;
        cfg_a(2'd2, 8'h40);
        chk("t4_eoi", isr_a, 8'h00);

        // Spurious acknowledge, then reset in the middle of ACK2.
        ack_a(vec, vv);
        chk("t5_spur_vv", vv, 1);
        chk("t5_spur_vec", vec, 8'h27);
        chk("t5_spur_isr", isr_a, 8'h00);
        irq_a = 8'h01;
        bus_a.interrupt_acknowledge_n = 1'b0; tick();
        chk("t5_isr_set", isr_a, 8'h01);
        bus_a.interrupt_acknowledge_n = 1'b1; tick();
        bus_a.interrupt_acknowledge_n = 1'b0; tick();
        chk("t5_vv_before_rst", bus_a.vector_valid, 1);
        chk("t5_vec_before_rst", bus_a.vector_out, 8'h20);
        rst_a = 1'b1;
        bus_a.interrupt_acknowledge_n = 1'b1; tick();
        chk("t5_vv_rst", bus_a.vector_valid, 0);
        chk("t5_isr_rst", isr_a, 8'h00);
        chk("t5_vec_rst", bus_a.vector_out, 8'h00);
        rst_a = 1'b0; irq_a = 8'h00; tick();
        cfg_a(2'd0, 8'h01);
        irq_a = 8'h01; tick();
        chk("t5_masked", bus_a.int_to_cpu, 0);
        cfg_a(2'd0, 8'h00);
        tick();
        chk("t5_unmasked", bus_a.int_to_cpu, 1);
        irq_a = 8'h00;

        // 16 channels: IR13 vector, auto-EOI where compiled in.
        cfg_b(2'd1, 16'h0040);
        cfg_b(2'd3, 16'h0002);
        irq_b = 16'h2000; tick();
        chk("t6_int", bus_b.int_to_cpu, 1);
        bus_b.interrupt_acknowledge_n = 1'b0; tick();
        chk("t6_isr_ack1", isr_b, 16'h2000);
        chk("t6_clr", clr_b, 16'h2000);
        irq_b = 16'h0000;
        bus_b.interrupt_acknowledge_n = 1'b1; tick();
        bus_b.interrupt_acknowledge_n = 1'b0; tick();
        chk("t6_vv", bus_b.vector_valid, 1);
        chk("t6_vec", bus_b.vector_out, 8'h4D);
        bus_b.interrupt_acknowledge_n = 1'b1; tick();
`ifdef AUTO_EOI_EN
        chk("t6_isr_after", isr_b, 16'h0000);
`else
        chk("t6_isr_after", isr_b, 16'h2000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
